// File: rtl/hilo_mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package hilo_mdu_pkg;

   localparam int DW_DEF = 32;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV_ISSUE,
      S_DIV_WAIT
   } state_e;

endpackage

// File: rtl/hilo_mdu_hilo_reg.sv
// HI/LO architectural registers. With HILO_BYPASS_EN defined the read ports
// forward the value being written at the coming edge.
module hilo_reg
   import hilo_mdu_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hi_we_i,
   input  logic          lo_we_i,
   input  logic [DW-1:0] hi_wdata_i,
   input  logic [DW-1:0] lo_wdata_i,
   output logic [DW-1:0] hi_rdata_o,
   output logic [DW-1:0] lo_rdata_o
);

   logic [DW-1:0] hi_q, lo_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         if (hi_we_i) hi_q <= hi_wdata_i;
         if (lo_we_i) lo_q <= lo_wdata_i;
      end
   end

`ifdef HILO_BYPASS_EN
   assign hi_rdata_o = hi_we_i ? hi_wdata_i : hi_q;
   assign lo_rdata_o = lo_we_i ? lo_wdata_i : lo_q;
`else
   assign hi_rdata_o = hi_q;
   assign lo_rdata_o = lo_q;
`endif

endmodule

// File: rtl/hilo_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO; divides run on an external
// iterative divider. Optional read bypass via HILO_BYPASS_EN (in hilo_reg).
module hilo_mdu
   import hilo_mdu_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          md_valid,
   input  logic [2:0]    md_op,
   input  logic [DW-1:0] src_a,
   input  logic [DW-1:0] src_b,
   output logic          md_stall,
   output logic [DW-1:0] hi_rdata,
   output logic [DW-1:0] lo_rdata,
   output logic          div_valid,
   output logic          div_sign,
   output logic [DW-1:0] div_a,
   output logic [DW-1:0] div_b,
   output logic          div_flush,
   input  logic          div_stall,
   input  logic [2*DW-1:0] div_result
);

   state_e state_q, state_d;
   logic [2*DW-1:0] prod_q, prod_d;
   logic [2*DW-1:0] ext_a, ext_b, prod_full;
   logic accept, is_mul, is_div, mul_sign;
   logic hi_we, lo_we;
   logic [DW-1:0] hi_wd, lo_wd;

   assign accept   = (state_q == S_IDLE) && md_valid && !flush;
   assign is_mul   = (md_op == MD_MULT) || (md_op == MD_MULTU);
   assign is_div   = (md_op == MD_DIV)  || (md_op == MD_DIVU);
   assign mul_sign = (md_op == MD_MULT);

   // Extending both operands to 2*DW makes the truncated product correct
   // for both signed and unsigned interpretations.
   assign ext_a     = mul_sign ? {{DW{src_a[DW-1]}}, src_a} : {{DW{1'b0}}, src_a};
   assign ext_b     = mul_sign ? {{DW{src_b[DW-1]}}, src_b} : {{DW{1'b0}}, src_b};
   assign prod_full = ext_a * ext_b;

   assign div_sign  = (md_op == MD_DIV);
   assign div_a     = src_a;
   assign div_b     = src_b;
   assign div_flush = flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         prod_q  <= prod_d;
      end
   end

   always_comb begin
      state_d = state_q;
      prod_d  = prod_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && is_mul) begin
               state_d = S_MUL;
               prod_d  = prod_full;
            end else if (accept && is_div) begin
               state_d = S_DIV_ISSUE;
            end
         end
         S_MUL:       state_d = S_IDLE;
         S_DIV_ISSUE: state_d = S_DIV_WAIT;
         S_DIV_WAIT:  if (!div_stall) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_comb begin
      md_stall  = 1'b0;
      div_valid = 1'b0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      hi_wd     = prod_q[2*DW-1:DW];
      lo_wd     = prod_q[DW-1:0];
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (md_op)
                  MD_MTHI: begin
                     hi_we = 1'b1;
                     hi_wd = src_a;
                  end
                  MD_MTLO: begin
                     lo_we = 1'b1;
                     lo_wd = src_a;
                  end
                  MD_MULT, MD_MULTU: md_stall = 1'b1;
                  MD_DIV, MD_DIVU: begin
                     div_valid = 1'b1;
                     md_stall  = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            hi_we = 1'b1;
            lo_we = 1'b1;
         end
         S_DIV_ISSUE: md_stall = 1'b1;
         S_DIV_WAIT: begin
            if (div_stall) begin
               md_stall = 1'b1;
            end else begin
               hi_we = 1'b1;
               lo_we = 1'b1;
               hi_wd = div_result[2*DW-1:DW];
               lo_wd = div_result[DW-1:0];
            end
         end
         default: ;
      endcase
      // A flush retires nothing: no write, no stall.
      if (flush) begin
         md_stall = 1'b0;
         hi_we    = 1'b0;
         lo_we    = 1'b0;
      end
   end

   hilo_reg #(.DW(DW)) u_hilo (
      .clk        (clk),
      .rst        (rst),
      .hi_we_i    (hi_we),
      .lo_we_i    (lo_we),
      .hi_wdata_i (hi_wd),
      .lo_wdata_i (lo_wd),
      .hi_rdata_o (hi_rdata),
      .lo_rdata_o (lo_rdata)
   );

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu with a behavioural 32-iteration divider.
module tb_hilo_mdu;
   import hilo_mdu_pkg::*;

   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst, flush, md_valid;
   logic [2:0] md_op;
   logic [DW-1:0] src_a, src_b;
   logic md_stall, div_valid, div_sign, div_flush, div_stall;
   logic [DW-1:0] hi_rdata, lo_rdata, div_a, div_b;
   logic [2*DW-1:0] div_result;

   int n_chk = 0;
   int n_err = 0;

   typedef struct { logic [31:0] hi; logic [31:0] lo; } exp_t;
   exp_t sb[$];
   logic [31:0] hi_m = '0, lo_m = '0;

   always #5 clk = ~clk;

   hilo_mdu #(.DW(DW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .md_valid(md_valid), .md_op(md_op),
      .src_a(src_a), .src_b(src_b), .md_stall(md_stall), .hi_rdata(hi_rdata),
      .lo_rdata(lo_rdata), .div_valid(div_valid), .div_sign(div_sign),
      .div_a(div_a), .div_b(div_b), .div_flush(div_flush),
      .div_stall(div_stall), .div_result(div_result)
   );

   // Divider model: stall rises one cycle after acceptance, held 32 cycles.
   logic [5:0] dcnt;
   logic [63:0] dres;
   assign div_stall  = (dcnt != 0) && (dcnt <= 6'd32);
   assign div_result = dres;

   function automatic logic [63:0] divmod(input logic s, input logic [31:0] a, input logic [31:0] b);
      int sa, sb2, q, r;
      logic [31:0] uq, ur;
      if (s) begin
         sa = a; sb2 = b;
         q = sa / sb2; r = sa % sb2;
         return {r[31:0], q[31:0]};
      end
      uq = a / b; ur = a % b;
      return {ur, uq};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         dcnt <= '0;
         dres <= '0;
      end else if (div_flush) begin
         dcnt <= '0;
      end else if (div_valid && dcnt == 0) begin
         dcnt <= 6'd33;
         dres <= divmod(div_sign, div_a, div_b);
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 6'd1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drives one op starting in the drive phase (just after a rising edge),
   // counts stall/div_valid cycles, then checks the committed HI/LO.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int exp_stall);
      int st = 0, dv = 0, cyc = 0;
      bit done = 0;
      exp_t e;
      sb.push_back('{ehi, elo});
      md_valid = 1'b1; md_op = op; src_a = a; src_b = b;
      while (!done && cyc < 100) begin
         @(negedge clk);
         if (div_valid) begin
            dv++;
            chk({tag, "_diva"}, {32'd0, div_a}, {32'd0, a});
            chk({tag, "_divsign"}, {63'd0, div_sign}, {63'd0, op == MD_DIV});
         end
         if (md_stall) st++; else done = 1;
         @(posedge clk); #1;
         md_valid = 1'b0; md_op = MD_NONE;
         src_a = $urandom; src_b = $urandom;
         cyc++;
      end
      if (!done) chk({tag, "_timeout"}, 64'd0, 64'd1);
      chk({tag, "_stalls"}, st, exp_stall);
      if (op == MD_DIV || op == MD_DIVU) chk({tag, "_divvalid"}, dv, 1);
      e = sb.pop_front();
      chk({tag, "_hi"}, {32'd0, hi_rdata}, {32'd0, e.hi});
      chk({tag, "_lo"}, {32'd0, lo_rdata}, {32'd0, e.lo});
      hi_m = e.hi; lo_m = e.lo;
   endtask

   initial begin
      logic [31:0] ra, rb;
      longint sp;
      longint unsigned up;
      rst = 1'b0; flush = 1'b0; md_valid = 1'b0; md_op = MD_NONE; src_a = '0; src_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {63'd0, md_stall}, 64'd0);
      chk("rst_divvalid", {63'd0, div_valid}, 64'd0);
      chk("rst_hi", {32'd0, hi_rdata}, 64'd0);
      chk("rst_lo", {32'd0, lo_rdata}, 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      run_op("mthi", MD_MTHI, 32'h12345678, 32'h0, 32'h12345678, lo_m, 0);
      run_op("mtlo", MD_MTLO, 32'h9ABCDEF0, 32'h0, hi_m, 32'h9ABCDEF0, 0);
      run_op("mult", MD_MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
      run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1);
      run_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 34);
      run_op("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
      run_op("divu", MD_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 34);

      for (int i = 0; i < 3; i++) begin
         ra = $urandom; rb = $urandom;
         sp = longint'($signed(ra)) * longint'($signed(rb));
         run_op("rnd_mult", MD_MULT, ra, rb, sp[63:32], sp[31:0], 1);
         up = {32'd0, ra} * {32'd0, rb};
         run_op("rnd_multu", MD_MULTU, ra, rb, up[63:32], up[31:0], 1);
         rb = rb | 32'h1;
         run_op("rnd_divu", MD_DIVU, ra, rb, ra % rb, ra / rb, 34);
      end

      // Flush at DIV_WAIT cycle 10
      md_valid = 1'b1; md_op = MD_DIV; src_a = 32'd50; src_b = 32'd3;
      @(negedge clk); @(posedge clk); #1;
      md_valid = 1'b0; md_op = MD_NONE;
      repeat (10) begin @(negedge clk); @(posedge clk); #1; end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_divflush", {63'd0, div_flush}, 64'd1);
      chk("flush_stall", {63'd0, md_stall}, 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("postflush_stall", {63'd0, md_stall}, 64'd0);
      chk("postflush_hi", {32'd0, hi_rdata}, {32'd0, hi_m});
      chk("postflush_lo", {32'd0, lo_rdata}, {32'd0, lo_m});
      @(posedge clk); #1;
      run_op("divu_after_flush", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34);

      // Op presented together with flush is dropped
      md_valid = 1'b1; md_op = MD_MTHI; src_a = 32'hDEADBEEF; flush = 1'b1;
      @(negedge clk);
      chk("flushop_stall", {63'd0, md_stall}, 64'd0);
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = MD_NONE; flush = 1'b0;
      @(negedge clk);
      chk("flushop_hi", {32'd0, hi_rdata}, {32'd0, hi_m});
      @(posedge clk); #1;

      // Same-cycle MFLO after MTLO
      md_valid = 1'b1; md_op = MD_MTLO; src_a = 32'h55;
      @(negedge clk);
`ifdef HILO_BYPASS_EN
      chk("bypass_lo", {32'd0, lo_rdata}, 64'h55);
`else
      chk("bypass_lo", {32'd0, lo_rdata}, {32'd0, lo_m});
`endif
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = MD_NONE;
      @(negedge clk);
      chk("mtlo_lo", {32'd0, lo_rdata}, 64'h55);
      lo_m = 32'h55;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
- Execute-stage multiply/divide unit with HI/LO ownership.
- Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage.
- Runs MULT/MULTU on an internal registered multiplier.
- Issues DIV/DIVU to the 32-iteration divider through its valid/stall handshake, consumes its {remainder, quotient} result and commits it to HI/LO.
- Supplies HI/LO read data for MFHI/MFLO and a pipeline stall.

Parameters:
- DW, 32, operand width; HI/LO are DW bits each, products and divider results are 2*DW.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush (exception/ERET); aborts any in-flight op
- md_valid  in  1  execute-stage op valid this cycle
- md_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- src_a  in  DW  rs value (dividend / multiplicand / MT data)
- src_b  in  DW  rt value (divisor / multiplier)
- md_stall  out  1  hold execute stage and upstream
- hi_rdata  out  DW  HI for MFHI
- lo_rdata  out  DW  LO for MFLO
- div_valid  out  1  divider start request
- div_sign  out  1  1 = signed (DIV)
- div_a  out  DW  dividend to divider
- div_b  out  DW  divisor to divider
- div_flush  out  1  abort to divider, equals flush
- div_stall  in  1  divider busy
- div_result  in  2*DW  {remainder, quotient}

Behaviour:
- Reset (rst low, async): state=IDLE, HI=0, LO=0, md_stall=0, div_valid=0, product register=0.
- States:
  - IDLE: accepts ops.
  - MUL: product registered.
  - DIV_ISSUE: divider accepted, waiting for stall to rise.
  - DIV_WAIT: divider busy.
- IDLE, md_valid & !flush:
  - MTHI/MTLO: HI/LO <= src_a at this edge. md_stall=0. Stay IDLE.
  - MULT/MULTU: product <= signed/unsigned src_a*src_b (2*DW). Next state MUL. md_stall=1 this cycle.
  - DIV/DIVU: div_valid=1 combinationally for exactly this cycle. div_a=src_a, div_b=src_b, div_sign=(op==DIV). Next state DIV_ISSUE. md_stall=1.
  - NONE/reserved: no effect.
- MUL: {HI,LO} <= product at this edge. md_stall=0 (instruction retires). Next state IDLE. Latency: MUL = 1 stall cycle.
- DIV_ISSUE: div_valid=0 (the divider relatches if valid is held while it is idle). md_stall=1. Go to DIV_WAIT unconditionally; the divider raises div_stall one cycle after acceptance.
- DIV_WAIT:
  - div_stall=1: md_stall=1, hold.
  - div_stall=0: {HI,LO} <= div_result, i.e. HI=remainder, LO=quotient. md_stall=0. Next state IDLE.
  - Total divide latency: 34 stall cycles from issue.
- Flush, any state:
  - State -> IDLE. No HI/LO write for the aborted op. div_flush=1 the same cycle. md_stall=0.
  - An op presented with flush is ignored.
- md_op is sampled only in IDLE. Operands change freely while stalled: the divider latches its operands and the multiplier uses the IDLE-cycle sample.
- Divide by zero: commit whatever the divider returns; no trap.
- md_valid with op NONE while busy: ignored (cannot occur while stalled).
- hi_rdata/lo_rdata: registered HI/LO unless the bypass below is compiled in.

Optional Feature:
- HILO_BYPASS_EN defined: hi_rdata/lo_rdata mux in the value being written at the coming edge (MTHI/MTLO data, product in MUL, div_result on DIV_WAIT completion). An MFHI immediately following sees the new value with no extra stall.
- HILO_BYPASS_EN undefined: outputs are the HI/LO registers only; writeback-side forwarding is external.

Decomposition:
- Shared package holds:
  - md_op encoding constants (MD_NONE..MD_MTLO)
  - state enum (S_IDLE, S_MUL, S_DIV_ISSUE, S_DIV_WAIT)
  - DW default
- One natural sub-module: hilo_reg (HI/LO storage with write-enable/select and the optional bypass mux). FSM and multiplier stay in hilo_mdu.

Test Plan:
- Reset, then MTHI 0x12345678, MTLO 0x9ABCDEF0 -> hi_rdata=0x12345678, lo_rdata=0x9ABCDEF0, md_stall never asserted.
- MULT 0xFFFFFFFF x 0x00000002 -> 1 stall cycle, HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV 7 / -2 with divider model -> div_valid high exactly 1 cycle, md_stall high 34 cycles, HI=0x00000001, LO=0xFFFFFFFD. DIV -7 / 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
- DIVU 0xFFFFFFFF / 0x10 -> HI=0x0000000F, LO=0x0FFFFFFF.
- DIV issued, flush at wait cycle 10 -> div_flush pulses, state IDLE, md_stall=0, HI/LO unchanged. A following DIVU 100/7 completes with HI=2, LO=14.
- With HILO_BYPASS_EN: MTLO 0x55 and MFLO sampled the same cycle -> lo_rdata=0x55. Without the macro -> old LO value, then 0x55 next cycle.
